// File: rtl/core_types_pkg.sv
// Shared core sizing constants and tag/pointer types for rename and free-list logic.
package core_types_pkg;

    localparam int unsigned NUM_ARCH_REGS          = 32;
    localparam int unsigned NUM_PHYS_REGS          = 64;
    localparam int unsigned LOG_PHYS_REGS          = 6;
    localparam int unsigned FREE_LIST_DEPTH        = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned LOG_FREE_LIST_DEPTH    = 5;
    localparam int unsigned CHECKPOINT_COLUMNS     = 4;
    localparam int unsigned LOG_CHECKPOINT_COLUMNS = 2;

    typedef logic [LOG_PHYS_REGS-1:0]          phys_reg_tag_t;
    typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
    // Extra MSB is the wrap bit so count = tail - head covers 0..DEPTH.
    typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;

endpackage

// File: rtl/checkpoint_ptr_table.sv
// Per-branch saved free-list head pointers: one write port, one combinational read port.
module checkpoint_ptr_table
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               write_valid,
    input  checkpoint_column_t write_column,
    input  free_list_ptr_t     write_ptr,
    input  checkpoint_column_t read_column,
    output free_list_ptr_t     read_ptr
);

    free_list_ptr_t columns [CHECKPOINT_COLUMNS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                columns[i] <= '0;
            end
        end else if (write_valid) begin
            columns[write_column] <= write_ptr;
        end
    end

    assign read_ptr = columns[read_column];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with checkpointed head for mispredict recovery.
module phys_reg_free_list
    import core_types_pkg::*;
#(
    parameter bit ASSERT_ILLEGAL = 1'b1
)
(
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         dispatch_dequeue_valid,
    output logic                         dispatch_dequeue_ready,
    output phys_reg_tag_t                dispatch_dequeue_phys_reg_tag,
    input  logic                         ROB_enqueue_valid,
    input  phys_reg_tag_t                ROB_enqueue_phys_reg_tag,
    input  logic                         checkpoint_save_valid,
    input  checkpoint_column_t           checkpoint_save_column,
    input  logic                         checkpoint_restore_valid,
    input  checkpoint_column_t           checkpoint_restore_column,
    output logic                         free_list_full,
    output logic                         free_list_empty,
    output logic [LOG_FREE_LIST_DEPTH:0] free_list_count
);

    phys_reg_tag_t  entries [FREE_LIST_DEPTH];
    free_list_ptr_t head;
    free_list_ptr_t tail;
    free_list_ptr_t head_next;
    free_list_ptr_t tail_next;
    free_list_ptr_t restore_ptr;
    logic           dequeue_fire;
    logic           enqueue_fire;

    always_comb begin
        free_list_count               = tail - head;
        free_list_full                = (free_list_count == free_list_ptr_t'(FREE_LIST_DEPTH));
        free_list_empty               = (free_list_count == '0);
        dispatch_dequeue_ready        = !free_list_empty;
        dispatch_dequeue_phys_reg_tag = entries[head[LOG_FREE_LIST_DEPTH-1:0]];
    end

    // Restore overrides any same-cycle dequeue; the save port stores head_next,
    // so a save alongside a restore captures the restored pointer.
    always_comb begin
        dequeue_fire = dispatch_dequeue_valid && dispatch_dequeue_ready && !checkpoint_restore_valid;
        enqueue_fire = ROB_enqueue_valid && !free_list_full;
        head_next    = checkpoint_restore_valid ? restore_ptr
                                                : head + free_list_ptr_t'(dequeue_fire);
        tail_next    = tail + free_list_ptr_t'(enqueue_fire);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head <= '0;
            tail <= free_list_ptr_t'(FREE_LIST_DEPTH);
        end else begin
            head <= head_next;
            tail <= tail_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
                entries[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            end
        end else if (enqueue_fire) begin
            entries[tail[LOG_FREE_LIST_DEPTH-1:0]] <= ROB_enqueue_phys_reg_tag;
        end
    end

    checkpoint_ptr_table u_checkpoint_ptr_table (
        .CLK          (CLK),
        .nRST         (nRST),
        .write_valid  (checkpoint_save_valid),
        .write_column (checkpoint_save_column),
        .write_ptr    (head_next),
        .read_column  (checkpoint_restore_column),
        .read_ptr     (restore_ptr)
    );

    a_no_dequeue_when_empty: assert property (@(posedge CLK) disable iff (!nRST || !ASSERT_ILLEGAL)
        !(dispatch_dequeue_valid && free_list_empty && !checkpoint_restore_valid));

    a_no_enqueue_when_full: assert property (@(posedge CLK) disable iff (!nRST || !ASSERT_ILLEGAL)
        !(ROB_enqueue_valid && free_list_full));

    a_count_bounded_after_restore: assert property (@(posedge CLK) disable iff (!nRST)
        checkpoint_restore_valid |=> (free_list_count <= free_list_ptr_t'(FREE_LIST_DEPTH)));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed table-driven bench for phys_reg_free_list plus hand sequences for wrap and async reset.
module tb_phys_reg_free_list;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       dispatch_dequeue_valid = 1'b0;
    logic       dispatch_dequeue_ready;
    logic [5:0] dispatch_dequeue_phys_reg_tag;
    logic       ROB_enqueue_valid = 1'b0;
    logic [5:0] ROB_enqueue_phys_reg_tag = '0;
    logic       checkpoint_save_valid = 1'b0;
    logic [1:0] checkpoint_save_column = '0;
    logic       checkpoint_restore_valid = 1'b0;
    logic [1:0] checkpoint_restore_column = '0;
    logic       free_list_full;
    logic       free_list_empty;
    logic [5:0] free_list_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    phys_reg_free_list #(.ASSERT_ILLEGAL(1'b0)) dut (
        .CLK                           (CLK),
        .nRST                          (nRST),
        .dispatch_dequeue_valid        (dispatch_dequeue_valid),
        .dispatch_dequeue_ready        (dispatch_dequeue_ready),
        .dispatch_dequeue_phys_reg_tag (dispatch_dequeue_phys_reg_tag),
        .ROB_enqueue_valid             (ROB_enqueue_valid),
        .ROB_enqueue_phys_reg_tag      (ROB_enqueue_phys_reg_tag),
        .checkpoint_save_valid         (checkpoint_save_valid),
        .checkpoint_save_column        (checkpoint_save_column),
        .checkpoint_restore_valid      (checkpoint_restore_valid),
        .checkpoint_restore_column     (checkpoint_restore_column),
        .free_list_full                (free_list_full),
        .free_list_empty               (free_list_empty),
        .free_list_count               (free_list_count)
    );

    typedef struct {
        logic       rst;
        logic       deq;
        logic       enq;
        logic [5:0] enq_tag;
        logic       save;
        logic [1:0] save_col;
        logic       restore;
        logic [1:0] rest_col;
        int         exp_count;
        logic       exp_ready;
        int         exp_tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic deq, input logic enq, input int tag,
                                input logic save, input int sc, input logic restore, input int rc,
                                input int cnt, input logic rdy, input int etag);
        vec_t v;
        v.rst = rst; v.deq = deq; v.enq = enq; v.enq_tag = 6'(tag);
        v.save = save; v.save_col = 2'(sc); v.restore = restore; v.rest_col = 2'(rc);
        v.exp_count = cnt; v.exp_ready = rdy; v.exp_tag = etag;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; applies one cycle of inputs and returns at the next posedge+1.
    task automatic step(input logic deq, input logic enq, input logic [5:0] tag,
                        input logic save, input logic [1:0] sc,
                        input logic restore, input logic [1:0] rc);
        dispatch_dequeue_valid    = deq;
        ROB_enqueue_valid         = enq;
        ROB_enqueue_phys_reg_tag  = tag;
        checkpoint_save_valid     = save;
        checkpoint_save_column    = sc;
        checkpoint_restore_valid  = restore;
        checkpoint_restore_column = rc;
        @(posedge CLK);
        #1;
        dispatch_dequeue_valid    = 1'b0;
        ROB_enqueue_valid         = 1'b0;
        checkpoint_save_valid     = 1'b0;
        checkpoint_restore_valid  = 1'b0;
    endtask

    task automatic do_reset();
        #2 nRST = 1'b0;
        #2 nRST = 1'b1;
    endtask

    task automatic check_state(input string name, input int cnt, input logic rdy, input int tag);
        check({name, ".count"}, 32'(free_list_count), 32'(cnt));
        check({name, ".ready"}, 32'(dispatch_dequeue_ready), 32'(rdy));
        check({name, ".full"},  32'(free_list_full), 32'(cnt == 32));
        check({name, ".empty"}, 32'(free_list_empty), 32'(cnt == 0));
        if (rdy) check({name, ".tag"}, 32'(dispatch_dequeue_phys_reg_tag), 32'(tag));
    endtask

    initial begin
        int q[$];
        int t;

        // Reset state
        #7;
        check_state("reset", 32, 1'b1, 32);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Drain all 32 reset tags in order, then an illegal dequeue on empty
        for (int i = 0; i < 32; i++) begin
            check($sformatf("drain%0d.tag", i), 32'(dispatch_dequeue_phys_reg_tag), 32'(32 + i));
            check($sformatf("drain%0d.ready", i), 32'(dispatch_dequeue_ready), 32'd1);
            step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        end
        check_state("drained", 0, 1'b0, 0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check_state("deq_on_empty", 0, 1'b0, 0);

        // Enqueue/dequeue from empty
        vecs.push_back(mk(0, 0, 1,  5, 0, 0, 0, 0, 1, 1, 5));
        vecs.push_back(mk(0, 0, 1,  9, 0, 0, 0, 0, 2, 1, 5));
        vecs.push_back(mk(0, 0, 1, 17, 0, 0, 0, 0, 3, 1, 5));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 2, 1, 9));
        vecs.push_back(mk(0, 1, 1, 20, 0, 0, 0, 0, 2, 1, 17));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 1, 1, 20));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // Save col 2 at reset head, dequeue 4, restore
        vecs.push_back(mk(1, 0, 0,  0, 1, 2, 0, 0, 32, 1, 32));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 31, 1, 33));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 30, 1, 34));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 29, 1, 35));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 28, 1, 36));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 2, 32, 1, 32));
        // Save with same-cycle dequeue; restore ignores dequeue; save+restore together
        vecs.push_back(mk(1, 1, 0,  0, 0, 0, 0, 0, 31, 1, 33));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 30, 1, 34));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 29, 1, 35));
        vecs.push_back(mk(0, 1, 0,  0, 1, 1, 0, 0, 28, 1, 36));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 27, 1, 37));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 1, 1, 28, 1, 36));
        vecs.push_back(mk(0, 0, 0,  0, 1, 3, 1, 1, 28, 1, 36));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 27, 1, 37));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 26, 1, 38));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 3, 28, 1, 36));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 27, 1, 37));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 26, 1, 38));
        vecs.push_back(mk(0, 0, 1,  7, 0, 0, 1, 1, 29, 1, 36));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].deq, vecs[i].enq, vecs[i].enq_tag, vecs[i].save, vecs[i].save_col,
                 vecs[i].restore, vecs[i].rest_col);
            check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ready, vecs[i].exp_tag);
        end

        // Wrap: 30 dequeues, then 40 enqueues (10 interleaved with dequeues) past index 31
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        q = '{62, 63};
        check_state("wrap_start", 2, 1'b1, 62);
        for (int k = 0; k < 40; k++) begin
            logic d;
            t = (k * 7 + 3) % 64;
            d = (k >= 10 && k < 20);
            step(d, 1'b1, 6'(t), 1'b0, '0, 1'b0, '0);
            if (d) void'(q.pop_front());
            q.push_back(t);
            check_state($sformatf("wrap%0d", k), q.size(), 1'b1, q[0]);
        end
        step(1'b0, 1'b1, 6'd55, 1'b0, '0, 1'b0, '0);
        check_state("enq_on_full", 32, 1'b1, q[0]);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("wrap_drain%0d.tag", k), 32'(dispatch_dequeue_phys_reg_tag), 32'(q[0]));
            step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
            void'(q.pop_front());
            check($sformatf("wrap_drain%0d.count", k), 32'(free_list_count), 32'(q.size()));
        end
        check_state("wrap_empty", 0, 1'b0, 0);

        // Async reset mid-stream with count 7, head 25; columns must be cleared
        do_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 2'd0, 1'b0, '0);
        check_state("pre_async", 7, 1'b1, 57);
        #2 nRST = 1'b0;
        #1;
        check_state("async_reset", 32, 1'b1, 32);
        #2 nRST = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd0);
        check_state("restore_cleared_col", 32, 1'b1, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Circular FIFO of free physical register tags. Sits between rename/dispatch, which reads (dequeues) tags, and the ROB, which writes (enqueues) tags back at commit or revert.
- Supports per-branch checkpointing of the read pointer so a mispredict restore returns all tags allocated after the branch in one cycle.
- Sized by the shared free-list and checkpoint constants in core_types_pkg.

Parameters:
- FREE_LIST_DEPTH, 32 (NUM_PHYS_REGS - NUM_ARCH_REGS): number of entries.
- LOG_FREE_LIST_DEPTH, 5: entry index width; pointers are LOG_FREE_LIST_DEPTH+1 bits (extra wrap bit).
- CHECKPOINT_COLUMNS, 4: number of saved head-pointer slots.
- NUM_ARCH_REGS, 32: tags 0..31 are arch-mapped at reset; tags 32..63 start in the list.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dispatch_dequeue_valid  in  1  dispatch consumes the head tag this cycle
- dispatch_dequeue_ready  out  1  list non-empty; head tag valid
- dispatch_dequeue_phys_reg_tag  out  6  head tag (phys_reg_tag_t)
- ROB_enqueue_valid  in  1  ROB returns a tag this cycle
- ROB_enqueue_phys_reg_tag  in  6  returned tag
- checkpoint_save_valid  in  1  save current head into a column
- checkpoint_save_column  in  2  column index (checkpoint_column_t)
- checkpoint_restore_valid  in  1  restore head from a column
- checkpoint_restore_column  in  2  column index
- free_list_full  out  1  count == FREE_LIST_DEPTH
- free_list_empty  out  1  count == 0
- free_list_count  out  6  tail - head, modulo 2^6

Behaviour:
- Reset (async, nRST low):
  - entry[i] = 32+i; head = 0; tail = 6'b100000 (wrapped, so full); all checkpoint columns = 0.
  - Outputs: ready=1, tag=32, full=1, empty=0, count=32.
- Outputs are combinational from registered state only (no input-to-output paths).
- Dequeue:
  - Fires when dispatch_dequeue_valid && dispatch_dequeue_ready; head increments next cycle.
  - valid while empty is ignored (no state change) and flagged by assertion. There is no same-cycle enqueue-to-dequeue bypass.
- Enqueue:
  - When ROB_enqueue_valid: entry[tail[4:0]] <= tag; tail increments.
  - Enqueue while full is dropped and flagged by assertion.
  - Simultaneous enqueue and dequeue are both applied, so count is unchanged.
- Save: column[checkpoint_save_column] <= head value after this cycle's dequeue, if any. The tag dequeued in the same cycle is not returned on restore.
- Restore:
  - head <= column[checkpoint_restore_column]; any same-cycle dequeue is ignored.
  - A same-cycle enqueue is still applied to tail.
  - Save and restore in the same cycle: restore wins for head; save writes the restored head value into its column.
- Pointer arithmetic: 6-bit wrap. Index = ptr[4:0]; full/empty derive from count, not from pointer bit comparison.
- Invariant asserted after restore: count <= FREE_LIST_DEPTH. A tag dequeued after a checkpoint is never enqueued before that checkpoint's restore.
- The list never reorders entries; the FIFO order of tags is exactly their enqueue order.

Decomposition:
- core_types_pkg already holds phys_reg_tag_t, checkpoint_column_t, FREE_LIST_DEPTH and LOG_FREE_LIST_DEPTH.
- Add free_list_ptr_t (logic [LOG_FREE_LIST_DEPTH:0]) to the package.
- Optional sub-module: checkpoint_ptr_table, the CHECKPOINT_COLUMNS x ptr register file with one write port and one read port. Everything else is flat.

Test Plan:
- Reset then 32 dequeues (one per cycle) -> tags 32..63 in order; after the last, empty=1, ready=0, count=0; a 33rd valid causes no state change.
- From empty, enqueue 5, 9, 17 -> count=3; dequeue yields 5, 9, 17 in order; enqueue and dequeue in the same cycle keep count constant.
- From reset, save column 2; dequeue 4 tags (32..35); restore column 2 -> count=32, next dequeued tag = 32.
- From reset, dequeue 3 (head=3); same cycle save col 1 + dequeue -> column 1 = 4; restore col 1 while dequeue_valid=1 -> head=4, dequeue ignored.
- Wrap: dequeue 30, enqueue 40 tags interleaved past index 31 -> pointers wrap; full asserts exactly at count 32; an extra enqueue is dropped.
- Assert nRST mid-stream (count=7, head=25) asynchronously -> immediate return to reset state; columns cleared; tag=32.
